// File: rtl/a_mmu_defines.sv
// Shared MMU definitions: TLB entry layout, write-port payload, maintenance op
// encodings and the page-size-aware VPPN compare used by lookup and maintenance.
package a_mmu_defines;

  localparam int unsigned TLB_ENTRY_NUM_DEF = 32;
  localparam int unsigned ASID_W            = 10;
  localparam int unsigned VPPN_W            = 19;
  localparam int unsigned PPN_W             = 20;
  localparam int unsigned INVOP_W           = 5;
  localparam int unsigned HUGE_CMP_W        = 10;

  typedef enum logic [2:0] {
    TLBOP_SRCH = 3'd0,
    TLBOP_RD   = 3'd1,
    TLBOP_WR   = 3'd2,
    TLBOP_FILL = 3'd3,
    TLBOP_INV  = 3'd4
  } tlbop_e;

  localparam logic [INVOP_W-1:0] INVOP_ALL0       = INVOP_W'(0);
  localparam logic [INVOP_W-1:0] INVOP_ALL1       = INVOP_W'(1);
  localparam logic [INVOP_W-1:0] INVOP_G1         = INVOP_W'(2);
  localparam logic [INVOP_W-1:0] INVOP_G0         = INVOP_W'(3);
  localparam logic [INVOP_W-1:0] INVOP_G0_ASID    = INVOP_W'(4);
  localparam logic [INVOP_W-1:0] INVOP_G0_ASID_VA = INVOP_W'(5);
  localparam logic [INVOP_W-1:0] INVOP_GASID_VA   = INVOP_W'(6);
  localparam logic [INVOP_W-1:0] INVOP_MAX        = INVOP_GASID_VA;

  // Encoded so that legal INVTLB ops map straight onto the low three bits.
  typedef enum logic [2:0] {
    MM_ALL0       = 3'd0,
    MM_ALL1       = 3'd1,
    MM_G1         = 3'd2,
    MM_G0         = 3'd3,
    MM_G0_ASID    = 3'd4,
    MM_G0_ASID_VA = 3'd5,
    MM_GASID_VA   = 3'd6
  } match_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } maint_state_e;

  typedef struct packed {
    logic [VPPN_W-1:0] vppn;
    logic              huge_page;
    logic              g;
    logic [ASID_W-1:0] asid;
    logic              e;
  } tlb_key_t;

  typedef struct packed {
    logic [PPN_W-1:0] ppn;
    logic [1:0]       plv;
    logic [1:0]       mat;
    logic             d;
    logic             v;
  } tlb_page_t;

  typedef struct packed {
    tlb_page_t p1;
    tlb_page_t p0;
  } tlb_data_t;

  typedef struct packed {
    tlb_key_t  key;
    tlb_data_t data;
  } tlb_entry_t;

  typedef struct packed {
    logic [TLB_ENTRY_NUM_DEF-1:0] tlb_write_req;
    tlb_entry_t                   tlb_write_entry;
  } tlb_write_req_t;

  // Huge pages ignore the low VPPN bits that fall inside the large page.
  function automatic logic tlb_vppn_match(input logic [VPPN_W-1:0] vppn,
                                          input logic              huge_page,
                                          input logic [VPPN_W-1:0] va_vppn);
    if (huge_page) begin
      return va_vppn[VPPN_W-1 -: HUGE_CMP_W] == vppn[VPPN_W-1 -: HUGE_CMP_W];
    end
    return va_vppn == vppn;
  endfunction

endpackage

// File: rtl/tlb_entry_match.sv
// Single-entry match for TLBSRCH and INVTLB; invalid entries never match.
module tlb_entry_match
  import a_mmu_defines::*;
(
  input  tlb_key_t          key_i,
  input  logic [ASID_W-1:0] asid_i,
  input  logic [VPPN_W-1:0] va_vppn_i,
  input  match_mode_e       mode_i,
  output logic              match_o
);

  logic asid_eq;
  logic va_eq;
  logic mode_match;

  assign asid_eq = (key_i.asid == asid_i);
  assign va_eq   = tlb_vppn_match(key_i.vppn, key_i.huge_page, va_vppn_i);

  always_comb begin
    mode_match = 1'b0;
    case (mode_i)
      MM_ALL0, MM_ALL1: mode_match = 1'b1;
      MM_G1:            mode_match = key_i.g;
      MM_G0:            mode_match = !key_i.g;
      MM_G0_ASID:       mode_match = !key_i.g && asid_eq;
      MM_G0_ASID_VA:    mode_match = !key_i.g && asid_eq && va_eq;
      MM_GASID_VA:      mode_match = (key_i.g || asid_eq) && va_eq;
      default:          mode_match = 1'b0;
    endcase
  end

  assign match_o = key_i.e && mode_match;

endmodule

// File: rtl/tlb_maint_ctrl.sv
// TLB maintenance sequencer: serialises SRCH/INV into one-entry-per-cycle sweeps
// over the array read port and issues single-entry writes for WR/FILL/INV.
module tlb_maint_ctrl
  import a_mmu_defines::*;
#(
  parameter int unsigned TLB_ENTRY_NUM = TLB_ENTRY_NUM_DEF,
  parameter int unsigned IDX_W         = $clog2(TLB_ENTRY_NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  tlbop_e               req_op_i,
  input  logic [INVOP_W-1:0]   req_invop_i,
  input  logic [ASID_W-1:0]    req_asid_i,
  input  logic [31:0]          req_va_i,
  input  logic [IDX_W-1:0]     req_idx_i,
  input  tlb_entry_t           req_entry_i,
  output logic [IDX_W-1:0]     rd_idx_o,
  input  tlb_entry_t           rd_entry_i,
  output tlb_write_req_t       tlb_write_req_o,
  output logic                 resp_valid_o,
  output logic                 resp_hit_o,
  output logic [IDX_W-1:0]     resp_idx_o,
  output tlb_entry_t           resp_entry_o,
  output logic                 resp_err_o
);

  maint_state_e        state_q, state_d;
  tlbop_e              op_q, op_d;
  logic [INVOP_W-1:0]  invop_q, invop_d;
  logic [ASID_W-1:0]   asid_q, asid_d;
  logic [VPPN_W-1:0]   vppn_q, vppn_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    k_q, k_d;
  logic [IDX_W-1:0]    fill_q, fill_d;
  logic [IDX_W-1:0]    hit_idx_q, hit_idx_d;
  logic                hit_q, hit_d;
  tlb_entry_t          entry_q, entry_d;

  logic                accept;
  logic                sweep_last;
  logic                inv_bad;
  logic                match;
  match_mode_e         mode;
  logic                unused_va_offset;

  assign accept           = req_valid_i && (state_q == ST_IDLE);
  assign sweep_last       = (k_q == IDX_W'(TLB_ENTRY_NUM - 1));
  assign inv_bad          = (invop_q > INVOP_MAX);
  assign mode             = (op_q == TLBOP_INV) ? match_mode_e'(invop_q[2:0]) : MM_GASID_VA;
  assign unused_va_offset = ^req_va_i[31-VPPN_W:0];

  tlb_entry_match u_match (
    .key_i     (rd_entry_i.key),
    .asid_i    (asid_q),
    .va_vppn_i (vppn_q),
    .mode_i    (mode),
    .match_o   (match)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          case (req_op_i)
            TLBOP_SRCH:            state_d = ST_SWEEP;
            TLBOP_WR, TLBOP_FILL:  state_d = ST_WRITE;
            TLBOP_INV:             state_d = (req_invop_i > INVOP_MAX) ? ST_RESP : ST_SWEEP;
            default:               state_d = ST_RESP;
          endcase
        end
      end
      ST_SWEEP: if (sweep_last) state_d = ST_RESP;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready_o     = 1'b0;
    rd_idx_o        = '0;
    tlb_write_req_o = '0;
    resp_valid_o    = 1'b0;
    resp_hit_o      = 1'b0;
    resp_idx_o      = '0;
    resp_entry_o    = '0;
    resp_err_o      = 1'b0;
    case (state_q)
      ST_IDLE: req_ready_o = 1'b1;
      ST_SWEEP: begin
        rd_idx_o = k_q;
        // Invalidate keeps every field except e so the array stays coherent.
        if ((op_q == TLBOP_INV) && match) begin
          tlb_write_req_o.tlb_write_req[k_q] = 1'b1;
          tlb_write_req_o.tlb_write_entry    = rd_entry_i;
          tlb_write_req_o.tlb_write_entry.key.e = 1'b0;
        end
      end
      ST_WRITE: begin
        tlb_write_req_o.tlb_write_req[idx_q] = 1'b1;
        tlb_write_req_o.tlb_write_entry      = entry_q;
      end
      ST_RESP: begin
        resp_valid_o = 1'b1;
        case (op_q)
          TLBOP_RD: begin
            rd_idx_o     = idx_q;
            resp_entry_o = rd_entry_i;
          end
          TLBOP_SRCH: begin
            resp_hit_o = hit_q;
            resp_idx_o = hit_idx_q;
          end
          TLBOP_FILL: resp_idx_o = idx_q;
          TLBOP_INV:  resp_err_o = inv_bad;
          default:    resp_err_o = 1'b0;
        endcase
      end
      default: req_ready_o = 1'b0;
    endcase
  end

  // Request latch, sweep index, search result and free-running fill counter
  always_comb begin
    op_d      = op_q;
    invop_d   = invop_q;
    asid_d    = asid_q;
    vppn_d    = vppn_q;
    idx_d     = idx_q;
    entry_d   = entry_q;
    k_d       = k_q;
    hit_d     = hit_q;
    hit_idx_d = hit_idx_q;
    fill_d    = fill_q + IDX_W'(1);
    if (accept) begin
      op_d      = req_op_i;
      invop_d   = req_invop_i;
      asid_d    = req_asid_i;
      vppn_d    = req_va_i[31 -: VPPN_W];
      idx_d     = (req_op_i == TLBOP_FILL) ? fill_q : req_idx_i;
      entry_d   = req_entry_i;
      k_d       = '0;
      hit_d     = 1'b0;
      hit_idx_d = '0;
    end else if (state_q == ST_SWEEP) begin
      k_d = k_q + IDX_W'(1);
      // First hit wins, giving the lowest matching index.
      if ((op_q == TLBOP_SRCH) && match && !hit_q) begin
        hit_d     = 1'b1;
        hit_idx_d = k_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= TLBOP_SRCH;
      invop_q   <= '0;
      asid_q    <= '0;
      vppn_q    <= '0;
      idx_q     <= '0;
      entry_q   <= '0;
      k_q       <= '0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
      fill_q    <= '0;
    end else begin
      op_q      <= op_d;
      invop_q   <= invop_d;
      asid_q    <= asid_d;
      vppn_q    <= vppn_d;
      idx_q     <= idx_d;
      entry_q   <= entry_d;
      k_q       <= k_d;
      hit_q     <= hit_d;
      hit_idx_q <= hit_idx_d;
      fill_q    <= fill_d;
    end
  end

endmodule
